// File: rtl/cello_sweep_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cello_sweep_pkg
//  Description : Shared types and constants for the Cello truth-table sweeper.
//                State encoding, row count, golden table default and the
//                row -> truth-table bit mapping helper.
//  Revision    : 1.0  initial release
// ============================================================================
package cello_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int          NUM_ROWS   = 16;
    localparam logic [3:0]  LAST_ROW   = 4'd15;
    localparam logic [15:0] DEFAULT_TT = 16'h47FD;

    // Row k of the truth table lives at bit (15-k): row 0 is the MSB.
    function automatic logic [3:0] row_bit(input logic [3:0] k);
        return LAST_ROW - k;
    endfunction

endpackage : cello_sweep_pkg
`default_nettype wire

// File: rtl/cello_tt_sweeper_timer.sv
`default_nettype none
// ============================================================================
//  Module      : sweep_settle_timer
//  Description : Loadable down-counter used to hold each input row for the
//                settle time. Saturates at zero; zero_o flags expiry.
//  Revision    : 1.0  initial release
//  Ports       : clk, rst     clock / asynchronous active-high reset
//                load_i       load value_i (has priority over dec_i)
//                dec_i        decrement by one when non-zero
//                value_i      CW-bit load value
//                zero_o       counter currently equals zero
// ============================================================================
module sweep_settle_timer #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          dec_i,
    input  logic [CW-1:0] value_i,
    output logic          zero_o
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule : sweep_settle_timer
`default_nettype wire

// File: rtl/cello_tt_sweeper.sv
`default_nettype none
// ============================================================================
//  Module      : cello_tt_sweeper
//  Description : Stimulus/capture stage for a 4-input Cello logic netlist.
//                Walks {in1,in2,in3,in4} through rows 0..15, holds each row
//                SETTLE_CYCLES clocks, samples dut_out, builds the observed
//                truth table (row k at bit 15-k) and compares it against
//                EXPECTED_TT.
//  Revision    : 1.0  initial release
//  Build macro : CELLO_SWEEP_SYNC_EN - when defined, dut_out goes through a
//                2-flop synchronizer before capture (SETTLE_CYCLES >= 3).
//  Ports       : clk, rst          clock / asynchronous active-high reset
//                start             request a sweep (accepted in IDLE only)
//                dut_out           netlist output
//                in1..in4          netlist inputs, row index bits 3..0
//                busy              accepted start through last SAMPLE
//                done              one-cycle completion pulse
//                observed_tt       captured table
//                mismatch_mask     observed_tt ^ EXPECTED_TT
//                pass              observed_tt == EXPECTED_TT
// ============================================================================
module cello_tt_sweeper
    import cello_sweep_pkg::*;
#(
    parameter int          SETTLE_CYCLES = 16,
    parameter logic [15:0] EXPECTED_TT   = DEFAULT_TT,
    parameter int          CW            = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        dut_out,
    output logic        in1,
    output logic        in2,
    output logic        in3,
    output logic        in4,
    output logic        busy,
    output logic        done,
    output logic [15:0] observed_tt,
    output logic [15:0] mismatch_mask,
    output logic        pass
);

    logic w_sample;

`ifdef CELLO_SWEEP_SYNC_EN
    localparam int MIN_SETTLE = 3;

    // Two-flop synchronizer; the captured value lags the pin by two clocks,
    // which the minimum settle time absorbs.
    logic [1:0] sync_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], dut_out};
        end
    end
    assign w_sample = sync_q[1];
`else
    localparam int MIN_SETTLE = 1;
    assign w_sample = dut_out;
`endif

    generate
        if ((SETTLE_CYCLES < MIN_SETTLE) || (SETTLE_CYCLES > (2**CW) - 1)) begin : g_bad_settle
            $fatal(1, "cello_tt_sweeper: SETTLE_CYCLES out of legal range");
        end
    endgenerate

    localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  row_q, row_d;
    logic [3:0]  in_q, in_d;
    logic [15:0] obs_q, obs_d;
    logic [15:0] mm_q, mm_d;
    logic        pass_q, pass_d;
    logic        w_load;
    logic        w_dec;
    logic        w_zero;

    sweep_settle_timer #(
        .CW (CW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (w_load),
        .dec_i   (w_dec),
        .value_i (RELOAD),
        .zero_o  (w_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            in_q    <= '0;
            obs_q   <= '0;
            mm_q    <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            in_q    <= in_d;
            obs_q   <= obs_d;
            mm_q    <= mm_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        obs_d   = obs_q;
        mm_d    = mm_q;
        pass_d  = pass_q;
        w_load  = 1'b0;
        w_dec   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    row_d   = '0;
                    obs_d   = '0;
                    mm_d    = '0;
                    pass_d  = 1'b0;
                    w_load  = 1'b1;
                end
            end
            DRIVE: begin
                w_dec = 1'b1;
                if (w_zero) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                obs_d[row_bit(row_q)] = w_sample;
                if (row_q == LAST_ROW) begin
                    // Compare results are frozen from the completed table
                    // so they are valid in the same cycle done pulses.
                    state_d = DONE;
                    mm_d    = obs_d ^ EXPECTED_TT;
                    pass_d  = (obs_d == EXPECTED_TT);
                end else begin
                    state_d = DRIVE;
                    row_d   = row_q + 4'd1;
                    w_load  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Netlist inputs are registered; they follow the row only while the
        // sweep is actively driving and fall back to zero otherwise.
        in_d = ((state_d == DRIVE) || (state_d == SAMPLE)) ? row_d : 4'd0;
    end

    assign {in1, in2, in3, in4} = in_q;
    assign busy          = (state_q == DRIVE) || (state_q == SAMPLE);
    assign done          = (state_q == DONE);
    assign observed_tt   = obs_q;
    assign mismatch_mask = mm_q;
    assign pass          = pass_q;

endmodule : cello_tt_sweeper
`default_nettype wire

// File: tb/tb_cello_tt_sweeper.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cello_tt_sweeper
//  Description : Directed self-checking bench for cello_tt_sweeper. A small
//                behavioural netlist model (selectable function) drives
//                dut_out from the sweeper's own in1..in4.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cello_tt_sweeper;

`ifdef CELLO_SWEEP_SYNC_EN
    localparam int S1 = 3;
`else
    localparam int S1 = 1;
`endif
    localparam int CYC0  = 16 * (16 + 1) + 1;   // 273
    localparam int CYC1  = 16 * (S1 + 1) + 1;   // 33 or 65
    localparam int LIMIT = 2000;

    logic clk = 1'b0;
    logic rst;
    logic start, start1;
    int   mode, mode1;
    logic [15:0] gold = 16'h47FD;

    logic        dout0, in1_0, in2_0, in3_0, in4_0, busy0, done0, pass0;
    logic [15:0] obs0, mm0;
    logic        dout1, in1_1, in2_1, in3_1, in4_1, busy1, done1, pass1;
    logic [15:0] obs1, mm1;
    logic [3:0]  row0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Netlist model: 0 = golden 0x47FD, 1 = stuck at 0, 2 = in4, 3 = in1
    function automatic logic model(input int m, input logic [15:0] g, input logic [3:0] r);
        case (m)
            0:       return g[4'd15 - r];
            1:       return 1'b0;
            2:       return r[0];
            default: return r[3];
        endcase
    endfunction

    assign row0  = {in1_0, in2_0, in3_0, in4_0};
    assign dout0 = model(mode,  gold, row0);
    assign dout1 = model(mode1, gold, {in1_1, in2_1, in3_1, in4_1});

    cello_tt_sweeper #(
        .SETTLE_CYCLES (16),
        .EXPECTED_TT   (16'h47FD),
        .CW            (8)
    ) dut (
        .clk (clk), .rst (rst), .start (start), .dut_out (dout0),
        .in1 (in1_0), .in2 (in2_0), .in3 (in3_0), .in4 (in4_0),
        .busy (busy0), .done (done0), .observed_tt (obs0),
        .mismatch_mask (mm0), .pass (pass0)
    );

    cello_tt_sweeper #(
        .SETTLE_CYCLES (S1),
        .EXPECTED_TT   (16'h47FD),
        .CW            (8)
    ) dut1 (
        .clk (clk), .rst (rst), .start (start1), .dut_out (dout1),
        .in1 (in1_1), .in2 (in2_1), .in3 (in3_1), .in4 (in4_1),
        .busy (busy1), .done (done1), .observed_tt (obs1),
        .mismatch_mask (mm1), .pass (pass1)
    );

    // Launch one sweep on the selected instance and return the cycle number
    // at which done is seen (start-sampling edge ends cycle 0), or -1.
    task automatic sweep(input int sel, output int cyc);
        @(posedge clk); #1;
        if (sel == 0) start = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start1 = 1'b0;
        cyc = 1;
        while (!(sel == 0 ? done0 : done1) && cyc < LIMIT) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!(sel == 0 ? done0 : done1)) cyc = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start1 = 1'b0; mode = 0; mode1 = 0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({row0, busy0, done0, obs0, mm0, pass0} !== 39'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h required 0", {row0, busy0, done0, obs0, mm0, pass0});
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({busy0, done0, pass0, busy1, done1} !== 5'd0) begin
            n_err++;
            $display("FAIL idle_after_reset: got %b required 00000", {busy0, done0, pass0, busy1, done1});
        end
    endtask

    task automatic test_golden();
        int cyc;
        mode = 0;
        sweep(0, cyc);
        n_vec++;
        if (cyc !== CYC0) begin n_err++; $display("FAIL golden_latency: got %0d required %0d", cyc, CYC0); end
        n_vec++;
        if (obs0 !== 16'h47FD) begin n_err++; $display("FAIL golden_tt: got %h required 47fd", obs0); end
        n_vec++;
        if (mm0 !== 16'h0000 || pass0 !== 1'b1) begin
            n_err++; $display("FAIL golden_compare: mask %h pass %b required 0000 1", mm0, pass0);
        end
        n_vec++;
        if (busy0 !== 1'b0 || row0 !== 4'd0) begin
            n_err++; $display("FAIL golden_done_state: busy %b row %h required 0 0", busy0, row0);
        end
        repeat (5) @(posedge clk);
        #1;
        n_vec++;
        if (done0 !== 1'b0 || obs0 !== 16'h47FD || pass0 !== 1'b1) begin
            n_err++; $display("FAIL golden_hold: done %b tt %h pass %b required 0 47fd 1", done0, obs0, pass0);
        end
    endtask

    task automatic test_fault();
        int cyc;
        mode = 1;
        sweep(0, cyc);
        n_vec++;
        if (cyc !== CYC0) begin n_err++; $display("FAIL fault_latency: got %0d required %0d", cyc, CYC0); end
        n_vec++;
        if (obs0 !== 16'h0000 || mm0 !== 16'h47FD || pass0 !== 1'b0) begin
            n_err++; $display("FAIL fault_compare: tt %h mask %h pass %b required 0000 47fd 0", obs0, mm0, pass0);
        end
    endtask

    task automatic test_row_order();
        int cyc;
        mode = 2;
        sweep(0, cyc);
        n_vec++;
        if (obs0 !== 16'h5555 || cyc !== CYC0) begin
            n_err++; $display("FAIL order_in4: tt %h cyc %0d required 5555 %0d", obs0, cyc, CYC0);
        end
        mode = 3;
        sweep(0, cyc);
        n_vec++;
        if (obs0 !== 16'h00FF || mm0 !== 16'h4702) begin
            n_err++; $display("FAIL order_in1: tt %h mask %h required 00ff 4702", obs0, mm0);
        end
    endtask

    task automatic test_reset_mid_sweep();
        int k;
        int nd;
        int cyc;
        mode = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        k = 0;
        while (row0 !== 4'd7 && k < 400) begin @(posedge clk); #1 k++; end
        n_vec++;
        if (row0 !== 4'd7) begin n_err++; $display("FAIL reach_row7: row %h required 7", row0); end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({row0, busy0, done0, obs0, mm0, pass0} !== 39'd0) begin
            n_err++; $display("FAIL midsweep_reset: got %h required 0", {row0, busy0, done0, obs0, mm0, pass0});
        end
        nd = 0;
        repeat (3) begin @(posedge clk); #1 if (done0) nd++; end
        rst = 1'b0;
        repeat (20) begin @(posedge clk); #1 if (done0) nd++; end
        n_vec++;
        if (nd !== 0) begin n_err++; $display("FAIL no_done_after_abort: got %0d required 0", nd); end
        // Fresh sweep must restart at row 0.
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n_vec++;
        if (busy0 !== 1'b1 || row0 !== 4'd0) begin
            n_err++; $display("FAIL restart_row0: busy %b row %h required 1 0", busy0, row0);
        end
        cyc = 1;
        while (!done0 && cyc < LIMIT) begin @(posedge clk); #1 cyc++; end
        n_vec++;
        if (cyc !== CYC0 || obs0 !== 16'h47FD || pass0 !== 1'b1) begin
            n_err++; $display("FAIL restart_sweep: cyc %0d tt %h pass %b required %0d 47fd 1", cyc, obs0, pass0, CYC0);
        end
    endtask

    task automatic test_start_while_busy();
        int  nd;
        int  first;
        bit  p3, p15;
        mode = 0; nd = 0; first = -1; p3 = 0; p15 = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int c = 1; c < 600; c++) begin
            if (done0) begin nd++; if (first < 0) first = c; end
            start = 1'b0;
            if (busy0 && row0 == 4'd3 && !p3) begin start = 1'b1; p3 = 1; end
            else if (busy0 && row0 == 4'd15 && !p15) begin start = 1'b1; p15 = 1; end
            @(posedge clk); #1;
        end
        start = 1'b0;
        n_vec++;
        if (!(p3 && p15)) begin n_err++; $display("FAIL busy_pulses_issued: p3 %b p15 %b required 1 1", p3, p15); end
        n_vec++;
        if (nd !== 1 || first !== CYC0) begin
            n_err++; $display("FAIL ignore_busy_start: dones %0d first %0d required 1 %0d", nd, first, CYC0);
        end
    endtask

    task automatic test_back_to_back();
        int d1, d2;
        mode = 0; d1 = -1; d2 = -1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c < 1200 && d2 < 0; c++) begin
            if (done0) begin
                if (d1 < 0) d1 = c;
                else begin d2 = c; start = 1'b0; end
            end
            if (d2 < 0) begin @(posedge clk); #1; end
        end
        start = 1'b0;
        n_vec++;
        if (d1 !== CYC0 || (d2 - d1) !== 274) begin
            n_err++; $display("FAIL back_to_back: first %0d spacing %0d required %0d 274", d1, d2 - d1, CYC0);
        end
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (busy0 !== 1'b0 || obs0 !== 16'h47FD) begin
            n_err++; $display("FAIL b2b_stop: busy %b tt %h required 0 47fd", busy0, obs0);
        end
    endtask

    task automatic test_short_settle();
        int cyc;
        mode1 = 0;
        sweep(1, cyc);
        n_vec++;
        if (cyc !== CYC1) begin n_err++; $display("FAIL short_latency: got %0d required %0d", cyc, CYC1); end
        n_vec++;
        if (obs1 !== 16'h47FD || mm1 !== 16'h0000 || pass1 !== 1'b1) begin
            n_err++; $display("FAIL short_golden: tt %h mask %h pass %b required 47fd 0000 1", obs1, mm1, pass1);
        end
        mode1 = 2;
        sweep(1, cyc);
        n_vec++;
        if (obs1 !== 16'h5555 || pass1 !== 1'b0) begin
            n_err++; $display("FAIL short_order: tt %h pass %b required 5555 0", obs1, pass1);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start1 = 1'b0; mode = 0; mode1 = 0;
        test_reset();
        test_golden();
        test_fault();
        test_row_order();
        test_reset_mid_sweep();
        test_start_while_busy();
        test_back_to_back();
        test_short_settle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_cello_tt_sweeper
`default_nettype wire
